// File: rtl/decoder_3_to_8_if.sv
// ---------------------------------------------------------------------------
// decoder_3_to_8_if
// Bundles the code/enable inputs and the registered select outputs of the
// one-hot decoder so that producer and decoder connect with a single port.
//
// Parameters
//   N : width of the binary code
//   M : width of the one-hot select vector (must be 2**N)
//
// Signals
//   enc   : binary code to decode                  (master -> slave)
//   en    : active-low enable, 0 = decode           (master -> slave)
//   dec   : registered one-hot select lines         (slave  -> master)
//   valid : registered flag, 1 when dec is one-hot  (slave  -> master)
//
// Modports
//   master : the logic that drives the code and consumes the selects
//   slave  : the decoder itself
// ---------------------------------------------------------------------------
interface decoder_3_to_8_if #(
  parameter int N = 3,
  parameter int M = 2 ** N
) ();

  logic [N-1:0] enc;
  logic         en;
  logic [M-1:0] dec;
  logic         valid;

  modport master (
    output enc,
    output en,
    input  dec,
    input  valid
  );

  modport slave (
    input  enc,
    input  en,
    output dec,
    output valid
  );

endinterface : decoder_3_to_8_if

// File: rtl/decoder_3_to_8.sv
// ---------------------------------------------------------------------------
// decoder_3_to_8
// Registered N-to-2**N one-hot decoder with an active-low enable. The select
// lines come straight from flops, so downstream bank/row selects and
// write-enable fan-out see glitch-free, cycle-aligned values one clock after
// the code is sampled.
//
// Parameters
//   N : width of the binary code (default 3)
//   M : width of the one-hot output, must equal 2**N (default 8)
//
// Ports
//   clk       : rising-edge clock
//   rst       : synchronous, active-high reset; clears dec and valid
//   bus.enc   : binary code to decode
//   bus.en    : active-low enable; 1 forces dec to zero on the next edge
//   bus.dec   : registered one-hot decode, bit dec[enc] set when enabled
//   bus.valid : registered flag, 1 when dec holds a one-hot value
// ---------------------------------------------------------------------------
module decoder_3_to_8 #(
  parameter int N = 3,
  parameter int M = 2 ** N
) (
  input  logic               clk,
  input  logic               rst,
  decoder_3_to_8_if.slave    bus
);

  // Any M other than 2**N would leave select lines unreachable or codes
  // without a line, so refuse to elaborate.
  if (M != (2 ** N)) begin : g_bad_width
    $error("decoder_3_to_8: M (%0d) must equal 2**N (%0d)", M, 2 ** N);
  end

  logic [M-1:0] w_dec_next;
  logic         w_valid_next;
  logic [M-1:0] r_dec;
  logic         r_valid;

  // Next-state decode: one-hot of enc when enabled, all zeros otherwise.
  always_comb begin
    w_dec_next   = {M{1'b0}};
    w_valid_next = 1'b0;
    if (bus.en == 1'b0) begin
      // Compare against each line index rather than indexing by enc, so an
      // unknown code can only affect the enabled path.
      for (int i = 0; i < M; i++) begin
        w_dec_next[i] = (bus.enc == N'(i));
      end
      w_valid_next = 1'b1;
    end else begin
      // Disabled: the code is ignored entirely, even if it is unknown.
      w_dec_next   = {M{1'b0}};
      w_valid_next = 1'b0;
    end
  end

  // Output register with synchronous reset taking priority over decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dec   <= {M{1'b0}};
      r_valid <= 1'b0;
    end else begin
      r_dec   <= w_dec_next;
      r_valid <= w_valid_next;
    end
  end

  assign bus.dec   = r_dec;
  assign bus.valid = r_valid;

endmodule : decoder_3_to_8

// File: tb/tb_decoder_3_to_8.sv
// ---------------------------------------------------------------------------
// tb_decoder_3_to_8
// Directed bench for the registered one-hot decoder: a default 3-to-8
// instance and a 4-to-16 instance, driven from tables of hand-computed
// expected select values.
// ---------------------------------------------------------------------------
module tb_decoder_3_to_8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  decoder_3_to_8_if #(.N(3), .M(8))  b3 ();
  decoder_3_to_8_if #(.N(4), .M(16)) b4 ();

  decoder_3_to_8 #(.N(3), .M(8)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (b3)
  );

  decoder_3_to_8 #(.N(4), .M(16)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (b4)
  );

  int n_checks = 0;
  int n_fails  = 0;

  // Hand-computed one-hot patterns for codes 0..7.
  logic [7:0] onehot_tbl [8] = '{
    8'b0000_0001, 8'b0000_0010, 8'b0000_0100, 8'b0000_1000,
    8'b0001_0000, 8'b0010_0000, 8'b0100_0000, 8'b1000_0000
  };

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and move away from it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk3(input string tag, input logic [7:0] e_dec,
                      input logic e_valid);
    check_val({tag, "_dec"},   32'(b3.dec),   32'(e_dec));
    check_val({tag, "_valid"}, 32'(b3.valid), 32'(e_valid));
    check_val({tag, "_pop"},   32'($countones(b3.dec)), e_valid ? 32'd1 : 32'd0);
  endtask

  initial begin
    // Reset for two edges with decode requested; reset must win.
    rst    = 1'b1;
    b3.en  = 1'b0;
    b3.enc = 3'd5;
    b4.en  = 1'b0;
    b4.enc = 4'd15;
    tick();
    chk3("reset0", 8'h00, 1'b0);
    check_val("reset0_dec16", 32'(b4.dec), 32'h0000);
    tick();
    chk3("reset1", 8'h00, 1'b0);

    // Enabled sweep over every code, including the MSB line.
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      b3.en  = 1'b0;
      b3.enc = 3'(i);
      tick();
      chk3($sformatf("sweep%0d", i), onehot_tbl[i], 1'b1);
      check_val($sformatf("sweep%0d_bit", i), 32'(b3.dec[i]), 32'd1);
    end

    // Disabled sweep: every code gives all zeros.
    for (int i = 0; i < 8; i++) begin
      b3.en  = 1'b1;
      b3.enc = 3'(i);
      tick();
      chk3($sformatf("dis%0d", i), 8'h00, 1'b0);
    end

    // Enable toggle with enc held at 3.
    b3.enc = 3'd3;
    b3.en  = 1'b0;
    tick();
    chk3("tog0", 8'b0000_1000, 1'b1);
    b3.en = 1'b1;
    tick();
    chk3("tog1", 8'b0000_0000, 1'b0);
    b3.en = 1'b0;
    tick();
    chk3("tog2", 8'b0000_1000, 1'b1);

    // Reset in the middle of a decode stream.
    b3.enc = 3'd6;
    tick();
    chk3("rp_pre", 8'b0100_0000, 1'b1);
    rst = 1'b1;
    tick();
    chk3("rp_rst", 8'h00, 1'b0);
    rst    = 1'b0;
    b3.enc = 3'd2;
    tick();
    chk3("rp_post", 8'b0000_0100, 1'b1);

    // Unknown code while disabled must not reach the outputs.
    b3.en  = 1'b1;
    b3.enc = 3'bxxx;
    tick();
    chk3("xenc", 8'h00, 1'b0);

    // Wider instance: top code, then disabled.
    b4.en  = 1'b0;
    b4.enc = 4'd15;
    tick();
    check_val("w16_dec",   32'(b4.dec),   32'h8000);
    check_val("w16_valid", 32'(b4.valid), 32'd1);
    b4.en = 1'b1;
    tick();
    check_val("w16_dis_dec",   32'(b4.dec),   32'h0000);
    check_val("w16_dis_valid", 32'(b4.valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule : tb_decoder_3_to_8

// File: doc/decoder_3_to_8.md
Name: decoder_3_to_8

Overview:
Registered n-to-2^n one-hot binary decoder with an active-low enable, default 3-to-8. Used wherever a small binary index must drive one-of-m select lines, e.g. bank/row selects and write-enable fan-out. The output is registered on one clock with a synchronous, active-high reset, so downstream logic sees glitch-free, cycle-aligned selects.

Parameters:
- n, 3, width of the binary input code.
- m, 2**n, width of the one-hot output. Must equal 2**n; any other value is illegal and the implementation shall flag it at elaboration.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- enc  input  n  binary code to decode.
- en  input  1  enable, active-low: 0 = decode, 1 = outputs forced to zero.
- dec  output  m  registered one-hot decode; bit dec[enc] is the selected line.
- valid  output  1  registered flag, 1 when dec holds a one-hot value, i.e. the previous cycle sampled en=0.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- All state updates on the rising edge of clk only. No combinational path from any input to any output.
- Reset: when rst=1 at a rising edge, dec <= 0 and valid <= 0, regardless of en or enc. rst has priority over every other input.
- Normal decode, when rst=0 and en=0 at a rising edge:
  - dec <= one-hot value with only bit enc set.
  - valid <= 1.
- Disabled, when rst=0 and en=1 at a rising edge: dec <= all zeros and valid <= 0, for every enc value.
- Latency: exactly 1 cycle. Outputs after edge k reflect the inputs sampled at edge k.
- Consecutive cycles: a new enc value may be presented every cycle, giving full throughput. There is no handshake and no backpressure.
- Invariants, each checked after every edge:
  - popcount(dec) is 0 or 1.
  - popcount(dec)=1 if and only if valid=1.
- X/Z on enc while en=1 shall not propagate: dec must still be all zeros.
- Power-up, before the first reset: outputs are undefined. The bench shall apply rst before checking.
- Reset mid-operation: asserting rst for one edge clears the outputs that cycle. Decoding resumes on the first edge with rst=0.
- Enable toggling: en changing from 0 to 1 clears dec on the next edge. en changing from 1 to 0 produces dec[enc] on the next edge. No extra cycles of latency in either direction.
- Wrap-around: enc=m-1 (7) drives dec[m-1]=1, i.e. the MSB, with no special case.

Test Plan:
- Reset: rst=1 for 2 cycles with en=0, enc=5 -> dec=8'b00000000 and valid=0 after each edge.
- Enabled sweep: rst=0, en=0, enc=0..7 one per cycle -> one cycle later, dec=8'b00000001, 00000010, ..., 10000000 and valid=1. Also checks dec[enc]=1 and popcount=1.
- Disabled sweep: en=1, enc=0..7 -> dec=8'b00000000 and valid=0 for every code.
- Enable toggle: enc=3 held, en sequence 0,1,0 on consecutive edges -> dec sequence 00001000, 00000000, 00001000.
- Reset priority mid-stream: en=0, enc=6 producing dec=01000000, then rst=1 for one edge -> dec=0 and valid=0. Release rst with enc=2 -> next edge dec=00000100.
- Parameter check: instantiate with n=4, m=16, en=0, enc=15 -> dec=16'h8000 one cycle later. With en=1 -> dec=16'h0000.
